// File: rtl/pc_update.sv
// rtl/pc_update.sv - next-PC stage: dnpc adder, PC register, IFU fetch handshake
// Optional redirect trace ring buffer enabled by defining PC_TRACE_EN.
module pc_update #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter int              TRACE_DEPTH = 8,
  localparam int             IDXW        = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_asrc,
  input  logic            pc_bsrc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jalr,
  input  logic            exec_valid,
  input  logic            ifu_ready,
  output logic            ifu_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic [XLEN-1:0] dnpc,
  output logic            misalign,
  input  logic [IDXW-1:0] trace_idx,
  output logic [XLEN-1:0] trace_src,
  output logic [XLEN-1:0] trace_dst,
  output logic [7:0]      trace_cnt
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] TRAP = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] sum;
  logic            commit;
  logic            redirect;

  assign sum       = (pc_asrc ? imm : XLEN'(4)) + (pc_bsrc ? rs1_data : pc);
  assign dnpc      = jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign snpc      = pc + XLEN'(4);
  assign ifu_valid = (state == REQ);
  assign commit    = (state == BUSY) && exec_valid && (dnpc[1:0] == 2'b00);
  assign redirect  = commit && (dnpc != snpc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= REQ;
        REQ:  if (ifu_ready) state <= BUSY;
        BUSY: begin
          if (exec_valid) begin
            if (dnpc[1:0] == 2'b00) begin
              pc    <= dnpc;
              state <= REQ;
            end else begin
              misalign <= 1'b1;
              state    <= TRAP;
            end
          end
        end
        default: state <= TRAP;
      endcase
    end
  end

`ifdef PC_TRACE_EN
  logic [XLEN-1:0]        src_mem [TRACE_DEPTH];
  logic [XLEN-1:0]        dst_mem [TRACE_DEPTH];
  logic [TRACE_DEPTH-1:0] entry_valid;
  logic [IDXW-1:0]        wptr;
  logic [IDXW-1:0]        rptr;

  // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
  assign rptr      = wptr - IDXW'(1) - trace_idx;
  assign trace_src = entry_valid[rptr] ? src_mem[rptr] : '0;
  assign trace_dst = entry_valid[rptr] ? dst_mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= '0;
      wptr        <= '0;
      trace_cnt   <= 8'd0;
    end else if (redirect) begin
      src_mem[wptr]     <= pc;
      dst_mem[wptr]     <= dnpc;
      entry_valid[wptr] <= 1'b1;
      wptr              <= wptr + IDXW'(1);
      if (trace_cnt != 8'hFF) trace_cnt <= trace_cnt + 8'd1;
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^trace_idx ^ redirect;
  assign trace_src    = '0;
  assign trace_dst    = '0;
  assign trace_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_pc_update.sv
// tb/tb_pc_update.sv - directed-vector bench for pc_update
module tb_pc_update;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_asrc = 1'b0, pc_bsrc = 1'b0, jalr = 1'b0;
  logic        exec_valid = 1'b0, ifu_ready = 1'b0;
  logic [31:0] imm = '0, rs1_data = '0;
  logic [2:0]  trace_idx = '0;
  logic        ifu_valid, misalign;
  logic [31:0] pc, snpc, dnpc, trace_src, trace_dst;
  logic [7:0]  trace_cnt;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] held;

  pc_update dut (
    .clk(clk), .rst(rst), .pc_asrc(pc_asrc), .pc_bsrc(pc_bsrc), .imm(imm),
    .rs1_data(rs1_data), .jalr(jalr), .exec_valid(exec_valid),
    .ifu_ready(ifu_ready), .ifu_valid(ifu_valid), .pc(pc), .snpc(snpc),
    .dnpc(dnpc), .misalign(misalign), .trace_idx(trace_idx),
    .trace_src(trace_src), .trace_dst(trace_dst), .trace_cnt(trace_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pc_asrc = 0; pc_bsrc = 0; jalr = 0; exec_valid = 0; ifu_ready = 0;
    imm = '0; rs1_data = '0; trace_idx = '0;
  endtask

  // Reset for one cycle, then one more cycle so the DUT sits in REQ.
  task automatic reset_to_req();
    clear_inputs();
    rst = 1; cyc(); rst = 0; cyc();
  endtask

  task automatic handshake();
    ifu_ready = 1; cyc(); ifu_ready = 0;
  endtask

  task automatic commit(input logic a, input logic b, input logic [31:0] im,
                        input logic [31:0] r1, input logic j);
    handshake();
    pc_asrc = a; pc_bsrc = b; imm = im; rs1_data = r1; jalr = j; exec_valid = 1;
    cyc();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; exec_valid = 1; ifu_ready = 1;
    cyc();
    rst = 0; exec_valid = 0; ifu_ready = 0;
    vectors++; if (pc !== 32'h8000_0000) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
    vectors++; if (ifu_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ifu_valid: got %b want 0", ifu_valid); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    vectors++; if (trace_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_trace_cnt: got %0d want 0", trace_cnt); end
    vectors++; if (snpc !== 32'h8000_0004) begin miscompares++; $display("FAIL reset_snpc: got %h want %h", snpc, 32'h8000_0004); end
    cyc();
    vectors++; if (ifu_valid !== 1'b1) begin miscompares++; $display("FAIL boot_to_req: got %b want 1", ifu_valid); end
  endtask

  task automatic test_seq();
    handshake();
    vectors++; if (ifu_valid !== 1'b0) begin miscompares++; $display("FAIL busy_ifu_valid: got %b want 0", ifu_valid); end
    vectors++; if (pc !== 32'h8000_0000) begin miscompares++; $display("FAIL busy_pc: got %h want %h", pc, 32'h8000_0000); end
    exec_valid = 1; #1;
    vectors++; if (dnpc !== 32'h8000_0004) begin miscompares++; $display("FAIL seq_dnpc: got %h want %h", dnpc, 32'h8000_0004); end
    cyc(); clear_inputs();
    vectors++; if (pc !== 32'h8000_0004) begin miscompares++; $display("FAIL seq_pc: got %h want %h", pc, 32'h8000_0004); end
    vectors++; if (ifu_valid !== 1'b1) begin miscompares++; $display("FAIL seq_back_in_req: got %b want 1", ifu_valid); end
  endtask

  task automatic test_branch();
    logic [31:0] e_src0, e_dst0, e_src1, e_dst1;
    logic [7:0]  e_cnt1, e_cnt2;
    reset_to_req();
    for (int i = 0; i < 4; i++) commit(0, 0, '0, '0, 0);
    vectors++; if (pc !== 32'h8000_0010) begin miscompares++; $display("FAIL branch_setup_pc: got %h want %h", pc, 32'h8000_0010); end
    handshake();
    pc_asrc = 1; imm = 32'hFFFF_FFF0; exec_valid = 1; #1;
    vectors++; if (dnpc !== 32'h8000_0000) begin miscompares++; $display("FAIL branch_dnpc: got %h want %h", dnpc, 32'h8000_0000); end
    cyc(); clear_inputs();
    vectors++; if (pc !== 32'h8000_0000) begin miscompares++; $display("FAIL branch_pc: got %h want %h", pc, 32'h8000_0000); end
`ifdef PC_TRACE_EN
    e_src0 = 32'h8000_0010; e_dst0 = 32'h8000_0000; e_cnt1 = 8'd1; e_cnt2 = 8'd2;
    e_src1 = 32'h8000_0000; e_dst1 = 32'h8000_0100;
`else
    e_src0 = '0; e_dst0 = '0; e_cnt1 = 8'd0; e_cnt2 = 8'd0; e_src1 = '0; e_dst1 = '0;
`endif
    trace_idx = 0; #1;
    vectors++; if (trace_src !== e_src0) begin miscompares++; $display("FAIL trace_src_first: got %h want %h", trace_src, e_src0); end
    vectors++; if (trace_dst !== e_dst0) begin miscompares++; $display("FAIL trace_dst_first: got %h want %h", trace_dst, e_dst0); end
    vectors++; if (trace_cnt !== e_cnt1) begin miscompares++; $display("FAIL trace_cnt_first: got %0d want %0d", trace_cnt, e_cnt1); end
    commit(1, 1, '0, 32'h8000_0100, 0);
    trace_idx = 0; #1;
    vectors++; if (trace_src !== e_src1) begin miscompares++; $display("FAIL trace_src_newest: got %h want %h", trace_src, e_src1); end
    vectors++; if (trace_dst !== e_dst1) begin miscompares++; $display("FAIL trace_dst_newest: got %h want %h", trace_dst, e_dst1); end
    vectors++; if (trace_cnt !== e_cnt2) begin miscompares++; $display("FAIL trace_cnt_second: got %0d want %0d", trace_cnt, e_cnt2); end
    trace_idx = 1; #1;
    vectors++; if (trace_src !== e_src0) begin miscompares++; $display("FAIL trace_src_older: got %h want %h", trace_src, e_src0); end
    trace_idx = 2; #1;
    vectors++; if (trace_dst !== 32'h0) begin miscompares++; $display("FAIL trace_unwritten: got %h want 0", trace_dst); end
    trace_idx = 0;
  endtask

  task automatic test_jalr();
    logic [7:0] e_cnt;
`ifdef PC_TRACE_EN
    e_cnt = 8'd2;
`else
    e_cnt = 8'd0;
`endif
    handshake();
    held = pc;
    pc_asrc = 1; pc_bsrc = 1; rs1_data = 32'h8000_1003; imm = '0; jalr = 1; exec_valid = 1; #1;
    vectors++; if (dnpc !== 32'h8000_1002) begin miscompares++; $display("FAIL jalr_dnpc: got %h want %h", dnpc, 32'h8000_1002); end
    cyc(); clear_inputs();
    vectors++; if (misalign !== 1'b1) begin miscompares++; $display("FAIL jalr_misalign: got %b want 1", misalign); end
    vectors++; if (pc !== held) begin miscompares++; $display("FAIL jalr_pc_held: got %h want %h", pc, held); end
    ifu_ready = 1; exec_valid = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++; if (ifu_valid !== 1'b0) begin miscompares++; $display("FAIL trap_ifu_valid[%0d]: got %b want 0", i, ifu_valid); end
    end
    clear_inputs();
    vectors++; if (trace_cnt !== e_cnt) begin miscompares++; $display("FAIL trap_not_traced: got %0d want %0d", trace_cnt, e_cnt); end
  endtask

  task automatic test_stall();
    reset_to_req();
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL trap_cleared_by_rst: got %b want 0", misalign); end
    exec_valid = 1; ifu_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      vectors++; if (ifu_valid !== 1'b1 || pc !== 32'h8000_0000) begin miscompares++; $display("FAIL stall[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, ifu_valid, pc, 32'h8000_0000); end
    end
    clear_inputs();
    commit(1, 1, '0, 32'hFFFF_FFFC, 0);
    vectors++; if (pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_setup_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
    vectors++; if (snpc !== 32'h0) begin miscompares++; $display("FAIL wrap_snpc: got %h want 0", snpc); end
    commit(0, 0, '0, '0, 0);
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", pc); end
  endtask

  task automatic test_rst_busy();
    reset_to_req();
    commit(1, 1, '0, 32'h8000_0040, 0);
    handshake();
    rst = 1; ifu_ready = 1; exec_valid = 1;
    cyc();
    rst = 0; clear_inputs();
    vectors++; if (pc !== 32'h8000_0000) begin miscompares++; $display("FAIL rst_busy_pc: got %h want %h", pc, 32'h8000_0000); end
    vectors++; if (ifu_valid !== 1'b0) begin miscompares++; $display("FAIL rst_busy_ifu_valid: got %b want 0", ifu_valid); end
    vectors++; if (trace_cnt !== 8'd0 || trace_src !== 32'h0) begin miscompares++; $display("FAIL rst_busy_trace: got cnt=%0d src=%h want 0/0", trace_cnt, trace_src); end
    vectors++; if (misalign !== 1'b0) begin miscompares++; $display("FAIL rst_busy_misalign: got %b want 0", misalign); end
    cyc();
    vectors++; if (ifu_valid !== 1'b1) begin miscompares++; $display("FAIL rst_busy_boot_req: got %b want 1", ifu_valid); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jalr();
    test_stall();
    test_rst_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
